// File: rtl/decode_writeback_param.sv
// decode_writeback_param: Y86-64 decode and write-back stage.
// Holds the register file, forwards operands from e/M/W, flags load-use hazards
// and owns the E pipeline register with stall/bubble control.
module decode_writeback_param #(
   parameter int unsigned DATA_W   = 64,
   parameter int unsigned NUM_REGS = 15,
   parameter int unsigned RSP_IDX  = 4,
   parameter int unsigned RSP_INIT = 254,
   parameter int unsigned RNONE    = 15
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [3:0]        D_stat,
   input  logic [3:0]        D_icode,
   input  logic [3:0]        D_ifun,
   input  logic [3:0]        D_rA,
   input  logic [3:0]        D_rB,
   input  logic [DATA_W-1:0] D_valC,
   input  logic [DATA_W-1:0] D_valP,
   input  logic [3:0]        e_destE,
   input  logic [DATA_W-1:0] e_valE,
   input  logic [3:0]        M_destE,
   input  logic [DATA_W-1:0] M_valE,
   input  logic [3:0]        M_destM,
   input  logic [DATA_W-1:0] m_valM,
   input  logic [3:0]        W_destE,
   input  logic [DATA_W-1:0] W_valE,
   input  logic [3:0]        W_destM,
   input  logic [DATA_W-1:0] W_valM,
   input  logic [3:0]        E_icode_in,
   input  logic [3:0]        E_destM_in,
   input  logic              E_stall,
   input  logic              E_bubble,
   input  logic [3:0]        dbg_addr,
   output logic [DATA_W-1:0] dbg_data,
   output logic [3:0]        d_srcA,
   output logic [3:0]        d_srcB,
   output logic              load_use,
   output logic [3:0]        E_stat,
   output logic [3:0]        E_icode,
   output logic [3:0]        E_ifun,
   output logic [DATA_W-1:0] E_valC,
   output logic [DATA_W-1:0] E_valA,
   output logic [DATA_W-1:0] E_valB,
   output logic [3:0]        E_srcA,
   output logic [3:0]        E_srcB,
   output logic [3:0]        E_destE,
   output logic [3:0]        E_destM
);

   localparam int unsigned RF_DEPTH = 16;
   localparam logic [3:0]  RN       = 4'(RNONE);
   localparam logic [3:0]  RSP      = 4'(RSP_IDX);
   localparam logic [3:0]  STAT_AOK = 4'b1000;

   localparam logic [3:0] I_NOP    = 4'h1;
   localparam logic [3:0] I_CMOV   = 4'h2;
   localparam logic [3:0] I_IRMOV  = 4'h3;
   localparam logic [3:0] I_RMMOV  = 4'h4;
   localparam logic [3:0] I_MRMOV  = 4'h5;
   localparam logic [3:0] I_OP     = 4'h6;
   localparam logic [3:0] I_JXX    = 4'h7;
   localparam logic [3:0] I_CALL   = 4'h8;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_PUSH   = 4'hA;
   localparam logic [3:0] I_POP    = 4'hB;

   // Storage is a full 4-bit address space; only indices below NUM_REGS are ever written.
   logic [DATA_W-1:0] rf_q [RF_DEPTH];

   logic [3:0]        src_a_d, src_b_d, dest_e_d, dest_m_d;
   logic [DATA_W-1:0] rd_a, rd_b, val_a_d, val_b_d;

   logic [3:0]        e_stat_q, e_icode_q, e_ifun_q;
   logic [DATA_W-1:0] e_valc_q, e_vala_q, e_valb_q;
   logic [3:0]        e_srca_q, e_srcb_q, e_deste_q, e_destm_q;

   function automatic logic in_rf(input logic [3:0] id);
      return (id != RN) && (32'(id) < NUM_REGS);
   endfunction

   // Register-ID decode from icode; every field defaults to "no register".
   always_comb begin
      src_a_d  = RN;
      src_b_d  = RN;
      dest_e_d = RN;
      dest_m_d = RN;
      case (D_icode)
         I_CMOV:  begin src_a_d = D_rA; dest_e_d = D_rB; end
         I_IRMOV: dest_e_d = D_rB;
         I_RMMOV: begin src_a_d = D_rA; src_b_d = D_rB; end
         I_MRMOV: begin src_b_d = D_rB; dest_m_d = D_rA; end
         I_OP:    begin src_a_d = D_rA; src_b_d = D_rB; dest_e_d = D_rB; end
         I_CALL:  begin src_b_d = RSP; dest_e_d = RSP; end
         I_RET:   begin src_a_d = RSP; src_b_d = RSP; dest_e_d = RSP; end
         I_PUSH:  begin src_a_d = D_rA; src_b_d = RSP; dest_e_d = RSP; end
         I_POP:   begin src_a_d = RSP; src_b_d = RSP; dest_e_d = RSP; dest_m_d = D_rA; end
         default: ;
      endcase
   end

   // Operand selection: valP for jumps/calls, then e > M(mem) > M(alu) > W(mem) > W(alu) > regfile.
   always_comb begin
      rd_a = in_rf(src_a_d) ? rf_q[src_a_d] : '0;
      rd_b = in_rf(src_b_d) ? rf_q[src_b_d] : '0;

      if (D_icode == I_JXX || D_icode == I_CALL) val_a_d = D_valP;
      else if (e_destE != RN && e_destE == src_a_d) val_a_d = e_valE;
      else if (M_destM != RN && M_destM == src_a_d) val_a_d = m_valM;
      else if (M_destE != RN && M_destE == src_a_d) val_a_d = M_valE;
      else if (W_destM != RN && W_destM == src_a_d) val_a_d = W_valM;
      else if (W_destE != RN && W_destE == src_a_d) val_a_d = W_valE;
      else                                           val_a_d = rd_a;

      if (e_destE != RN && e_destE == src_b_d)      val_b_d = e_valE;
      else if (M_destM != RN && M_destM == src_b_d) val_b_d = m_valM;
      else if (M_destE != RN && M_destE == src_b_d) val_b_d = M_valE;
      else if (W_destM != RN && W_destM == src_b_d) val_b_d = W_valM;
      else if (W_destE != RN && W_destE == src_b_d) val_b_d = W_valE;
      else                                           val_b_d = rd_b;
   end

   // Write-back: the memory port is issued last so it wins when both target one register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < RF_DEPTH; i++) begin
            rf_q[4'(i)] <= (i == RSP_IDX) ? DATA_W'(RSP_INIT) : '0;
         end
      end else begin
         if (in_rf(W_destE)) rf_q[W_destE] <= W_valE;
         if (in_rf(W_destM)) rf_q[W_destM] <= W_valM;
      end
   end

   // E pipeline register: bubble beats stall, otherwise capture the decoded instruction.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n || E_bubble) begin
         if (!rst_n || E_bubble) begin
            e_stat_q  <= STAT_AOK;
            e_icode_q <= I_NOP;
            e_ifun_q  <= '0;
            e_valc_q  <= '0;
            e_vala_q  <= '0;
            e_valb_q  <= '0;
            e_srca_q  <= RN;
            e_srcb_q  <= RN;
            e_deste_q <= RN;
            e_destm_q <= RN;
         end
      end else if (!E_stall) begin
         e_stat_q  <= D_stat;
         e_icode_q <= D_icode;
         e_ifun_q  <= D_ifun;
         e_valc_q  <= D_valC;
         e_vala_q  <= val_a_d;
         e_valb_q  <= val_b_d;
         e_srca_q  <= src_a_d;
         e_srcb_q  <= src_b_d;
         e_deste_q <= dest_e_d;
         e_destm_q <= dest_m_d;
      end
   end

   assign d_srcA   = src_a_d;
   assign d_srcB   = src_b_d;
   assign load_use = (E_icode_in == I_MRMOV || E_icode_in == I_POP) &&
                     (E_destM_in == src_a_d || E_destM_in == src_b_d);
   assign dbg_data = in_rf(dbg_addr) ? rf_q[dbg_addr] : '0;

   assign E_stat  = e_stat_q;
   assign E_icode = e_icode_q;
   assign E_ifun  = e_ifun_q;
   assign E_valC  = e_valc_q;
   assign E_valA  = e_vala_q;
   assign E_valB  = e_valb_q;
   assign E_srcA  = e_srca_q;
   assign E_srcB  = e_srcb_q;
   assign E_destE = e_deste_q;
   assign E_destM = e_destm_q;

endmodule
